// File: rtl/apb_completer_regfile.sv
// APB4 completer exposing a bank of 32-bit registers with programmable wait states.
// Out-of-range, misaligned and read-only-write accesses complete with pslverr.
package apb_completer_regfile_pkg;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned IDX_MAX_W = 6;

  typedef struct packed {
    logic                 write;
    logic [IDX_MAX_W-1:0] idx;
    logic [DATA_W-1:0]    wdata;
    logic [STRB_W-1:0]    strb;
  } apb_req_t;
endpackage

module apb_completer_regfile
  import apb_completer_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [63:0] RO_MASK     = 64'h0
) (
  input  logic                         s_apb_pclk,
  input  logic                         s_apb_preset,
  input  logic                         s_apb_psel,
  input  logic                         s_apb_penable,
  input  logic                         s_apb_pwrite,
  input  logic [31:0]                  s_apb_paddr,
  input  logic [DATA_W-1:0]            s_apb_pwdata,
  input  logic [STRB_W-1:0]            s_apb_pstrb,
  input  logic [2:0]                   s_apb_pprot,
  output logic                         s_apb_pready,
  output logic [DATA_W-1:0]            s_apb_prdata,
  output logic                         s_apb_pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [NUM_REGS-1:0] RO_VEC = RO_MASK[NUM_REGS-1:0];

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  apb_req_t            req_q, req_c;
  logic                err_q, err_c;
  logic [DATA_W-1:0]   rdata_q, rdata_c;
  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [DATA_W-1:0]   hw_arr  [NUM_REGS];
  logic [31:0]         off_c;
  logic [29:0]         idx_full_c;
  logic [IDX_W-1:0]    sel_c;
  logic [IDX_W-1:0]    widx_c;
  logic                setup_c;
  logic                pready_c;
  logic                commit_c;
  logic                unused_ok;

  assign unused_ok = ^{s_apb_pprot, off_c[1:0]};

  // Flat views of the register bank and the hardware read inputs
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_W +: DATA_W] = regs[i];
      hw_arr[i]                   = hw_in[i*DATA_W +: DATA_W];
    end
  end

  // Address decode and read data for the request presented in the setup phase
  always_comb begin
    off_c      = s_apb_paddr - BASE_ADDR;
    idx_full_c = off_c[31:2];
    sel_c      = IDX_W'(idx_full_c);
    err_c      = (s_apb_paddr < BASE_ADDR)
               | (idx_full_c >= 30'(NUM_REGS))
               | (s_apb_paddr[1:0] != 2'b00);
    if (!err_c && s_apb_pwrite && RO_VEC[sel_c]) err_c = 1'b1;
    rdata_c = '0;
    if (!err_c) rdata_c = RO_VEC[sel_c] ? hw_arr[sel_c] : regs[sel_c];
    req_c.write = s_apb_pwrite;
    req_c.idx   = IDX_MAX_W'(idx_full_c);
    req_c.wdata = s_apb_pwdata;
    req_c.strb  = s_apb_pstrb;
  end

  assign setup_c  = (state_q == ST_IDLE) & s_apb_psel & ~s_apb_penable;
  assign pready_c = (state_q == ST_WAIT) & s_apb_psel & s_apb_penable & (cnt_q == '0);
  assign commit_c = pready_c & req_q.write & ~err_q;
  assign widx_c   = IDX_W'(req_q.idx);

  assign s_apb_pready  = pready_c;
  assign s_apb_pslverr = pready_c & err_q;
  assign s_apb_prdata  = (pready_c & ~req_q.write) ? rdata_q : '0;

  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup_c) state_d = ST_WAIT;
      ST_WAIT: if (!s_apb_psel || pready_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and register commit
  always_ff @(posedge s_apb_pclk) begin
    if (s_apb_preset) begin
      cnt_q    <= '0;
      req_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (setup_c) begin
        req_q   <= req_c;
        err_q   <= err_c;
        rdata_q <= rdata_c;
        cnt_q   <= CNT_W'(WAIT_STATES);
      end else if ((state_q == ST_WAIT) && s_apb_psel && s_apb_penable && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit_c) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (req_q.strb[b]) regs[widx_c][8*b +: 8] <= req_q.wdata[8*b +: 8];
        end
        wr_pulse[widx_c] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench for apb_completer_regfile: two instances (2 wait states with an RO
// register, zero-wait with a nonzero base) checked every cycle against a transfer-level model.
module tb_apb_completer_regfile;
  localparam int NR = 16;
  localparam int W  = NR * 32;

  logic            clk, preset;
  logic            psel    [2];
  logic            penable [2];
  logic            pwrite  [2];
  logic [31:0]     paddr   [2];
  logic [31:0]     pwdata  [2];
  logic [3:0]      pstrb   [2];
  logic [2:0]      pprot;
  logic            pready  [2];
  logic [31:0]     prdata  [2];
  logic            pslverr [2];
  logic [W-1:0]    reg_out [2];
  logic [W-1:0]    hw_in   [2];
  logic [NR-1:0]   wr_pulse[2];

  apb_completer_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2), .RO_MASK(64'h4)) dut0 (
    .s_apb_pclk(clk), .s_apb_preset(preset), .s_apb_psel(psel[0]), .s_apb_penable(penable[0]),
    .s_apb_pwrite(pwrite[0]), .s_apb_paddr(paddr[0]), .s_apb_pwdata(pwdata[0]), .s_apb_pstrb(pstrb[0]),
    .s_apb_pprot(pprot), .s_apb_pready(pready[0]), .s_apb_prdata(prdata[0]), .s_apb_pslverr(pslverr[0]),
    .reg_out(reg_out[0]), .hw_in(hw_in[0]), .wr_pulse(wr_pulse[0]));

  apb_completer_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0), .RO_MASK(64'h0)) dut1 (
    .s_apb_pclk(clk), .s_apb_preset(preset), .s_apb_psel(psel[1]), .s_apb_penable(penable[1]),
    .s_apb_pwrite(pwrite[1]), .s_apb_paddr(paddr[1]), .s_apb_pwdata(pwdata[1]), .s_apb_pstrb(pstrb[1]),
    .s_apb_pprot(pprot), .s_apb_pready(pready[1]), .s_apb_prdata(prdata[1]), .s_apb_pslverr(pslverr[1]),
    .reg_out(reg_out[1]), .hw_in(hw_in[1]), .wr_pulse(wr_pulse[1]));

  always #5 clk = ~clk;

  // Model state
  logic [31:0]   mem        [2][NR];
  logic          exp_pready [2];
  logic [31:0]   exp_prdata [2];
  logic          exp_pslverr[2];
  logic [NR-1:0] exp_wp     [2];
  bit            pend_v     [2];
  int            pend_idx   [2];
  logic [31:0]   pend_data  [2];
  logic [3:0]    pend_strb  [2];
  bit            chk_en;
  int            n_chk, n_pass;

  function automatic int ws_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic logic [31:0] base_of(int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction
  function automatic logic [15:0] ro_of(int d);
    return (d == 0) ? 16'h0004 : 16'h0000;
  endfunction

  function automatic bit m_err(int d, bit wr, logic [31:0] a);
    logic [31:0] b;
    logic [31:0] off;
    logic [15:0] ro;
    b = base_of(d);
    if (a < b) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    off = a - b;
    if (off / 4 >= NR) return 1'b1;
    ro = ro_of(d);
    if (wr && ro[off / 4]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] flat(int d);
    logic [W-1:0] r;
    for (int i = 0; i < NR; i++) r[i*32 +: 32] = mem[d][i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, W'(act), W'(exp));
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, W'(act), W'(exp));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) mem[d][i] = '0;
      pend_v[d] = 0; exp_wp[d] = '0;
      exp_pready[d] = 0; exp_prdata[d] = '0; exp_pslverr[d] = 0;
    end
  endtask

  // Advance one clock; apply writes committed at this edge to the model
  task automatic step();
    logic [31:0] mask;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      exp_wp[d] = '0;
      if (pend_v[d]) begin
        mask = {{8{pend_strb[d][3]}}, {8{pend_strb[d][2]}}, {8{pend_strb[d][1]}}, {8{pend_strb[d][0]}}};
        mem[d][pend_idx[d]] = (mem[d][pend_idx[d]] & ~mask) | (pend_data[d] & mask);
        exp_wp[d] = NR'(1) << pend_idx[d];
        pend_v[d] = 0;
      end
      exp_pready[d] = 0; exp_prdata[d] = '0; exp_pslverr[d] = 0;
    end
  endtask

  // One APB transfer; abort_k/reset_k name the access cycle to drop psel or assert reset
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int abort_k, input int reset_k,
                      output logic [31:0] rd, output logic se);
    bit e;
    int idx, n;
    logic [31:0] rdx;
    logic [15:0] ro;
    n = ws_of(d) + 1;
    e = m_err(d, wr, a);
    idx = int'((a - base_of(d)) >> 2);
    ro = ro_of(d);
    rdx = '0;
    if (!e) rdx = ro[idx] ? hw_in[d][idx*32 +: 32] : mem[d][idx];
    rd = '0; se = 0;
    psel[d] = 1; penable[d] = 0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    step();
    for (int k = 1; k <= n; k++) begin
      penable[d] = 1;
      if (k == abort_k) begin
        psel[d] = 0; penable[d] = 0;
        step();
        return;
      end
      if (k == reset_k) begin
        preset = 1;
        step();
        model_reset();
        preset = 0; psel[d] = 0; penable[d] = 0;
        return;
      end
      if (k == n) begin
        exp_pready[d] = 1; exp_prdata[d] = wr ? 32'h0 : rdx; exp_pslverr[d] = e;
        @(negedge clk);
        rd = prdata[d]; se = pslverr[d];
        if (wr && !e) begin
          pend_v[d] = 1; pend_idx[d] = idx; pend_data[d] = wd; pend_strb[d] = st;
        end
      end
      step();
    end
    psel[d] = 0; penable[d] = 0;
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk1($sformatf("pready%0d", d), pready[d], exp_pready[d]);
        chk32($sformatf("prdata%0d", d), prdata[d], exp_prdata[d]);
        chk1($sformatf("pslverr%0d", d), pslverr[d], exp_pslverr[d]);
        chk($sformatf("wr_pulse%0d", d), W'(wr_pulse[d]), W'(exp_wp[d]));
        chk($sformatf("reg_out%0d", d), reg_out[d], flat(d));
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        se;
    clk = 0; preset = 1; pprot = 3'b010; chk_en = 0; n_chk = 0; n_pass = 0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    for (int i = 0; i < NR; i++) hw_in[0][i*32 +: 32] = 32'h5A5A_0000 + 32'(i);
    hw_in[0][95:64] = 32'h0000_CAFE;
    hw_in[1] = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1; preset = 0; chk_en = 1;
    @(negedge clk);
    chk1("rst_pready", pready[0], 1'b0);
    chk32("rst_prdata", prdata[0], 32'h0);
    chk("rst_reg_out", reg_out[0], '0);
    chk("rst_wr_pulse", W'(wr_pulse[0]), '0);
    step();

    xfer(0, 1, 32'h0C, 32'hDEAD_BEEF, 4'hF, -1, -1, rd, se);
    chk1("wr3_slverr", se, 1'b0);
    step();
    chk32("reg_out3", reg_out[0][127:96], 32'hDEAD_BEEF);
    xfer(0, 0, 32'h0C, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("rd3", rd, 32'hDEAD_BEEF);

    xfer(0, 1, 32'h14, 32'h1122_3344, 4'hF, -1, -1, rd, se);
    xfer(0, 1, 32'h14, 32'hAABB_CCDD, 4'b0101, -1, -1, rd, se);
    xfer(0, 0, 32'h14, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("rd5_partial", rd, 32'h11BB_33DD);

    xfer(0, 0, 32'h40, 32'h0, 4'h0, -1, -1, rd, se);
    chk1("oor_slverr", se, 1'b1);
    chk32("oor_prdata", rd, 32'h0);
    xfer(0, 1, 32'h06, 32'h5555_5555, 4'hF, -1, -1, rd, se);
    chk1("misalign_slverr", se, 1'b1);

    xfer(0, 1, 32'h08, 32'hFFFF_FFFF, 4'hF, -1, -1, rd, se);
    chk1("ro_wr_slverr", se, 1'b1);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("ro_rd", rd, 32'h0000_CAFE);
    chk1("ro_rd_slverr", se, 1'b0);

    xfer(0, 1, 32'h10, 32'h1234_5678, 4'h0, -1, -1, rd, se);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("strb0_rd", rd, 32'h0);
    xfer(0, 1, 32'h3C, 32'hA5A5_A5A5, 4'hF, -1, -1, rd, se);
    xfer(0, 0, 32'h3C, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("last_reg_rd", rd, 32'hA5A5_A5A5);

    xfer(0, 1, 32'h10, 32'h1234_5678, 4'hF, 2, -1, rd, se);
    step();
    chk32("abort_noupd", reg_out[0][159:128], 32'h0);

    xfer(1, 1, 32'h1000, 32'hCAFE_F00D, 4'hF, -1, -1, rd, se);
    xfer(1, 0, 32'h1000, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("b2b_rd", rd, 32'hCAFE_F00D);
    xfer(1, 0, 32'h0FFC, 32'h0, 4'h0, -1, -1, rd, se);
    chk1("below_base_slverr", se, 1'b1);
    xfer(1, 0, 32'h1040, 32'h0, 4'h0, -1, -1, rd, se);
    chk1("above_top_slverr", se, 1'b1);
    xfer(1, 1, 32'h1004, 32'h0102_0304, 4'b0011, -1, -1, rd, se);
    xfer(1, 0, 32'h1004, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("ws0_partial", rd, 32'h0000_0304);

    xfer(0, 1, 32'h04, 32'h7777_7777, 4'hF, -1, 1, rd, se);
    chk("rst_wait_reg0", reg_out[0], '0);
    chk("rst_wait_reg1", reg_out[1], '0);
    chk1("rst_wait_pready", pready[0], 1'b0);
    xfer(0, 1, 32'h04, 32'h0BAD_F00D, 4'hF, -1, -1, rd, se);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("post_rst_rd", rd, 32'h0BAD_F00D);
    xfer(0, 0, 32'h0C, 32'h0, 4'h0, -1, -1, rd, se);
    chk32("post_rst_rd3", rd, 32'h0);
    step();
    step();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
